// File: rtl/joy_serial_reader.sv
// Scans two DB9 joysticks through an external 74HC165 chain: parallel load, then
// 16 serial bits, latched into the joystick outputs once per frame.
module joy_serial_reader #(
    parameter int CLKDIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       joy_load_n,
    output logic       joy_clk,
    input  logic       joy_data,
    output logic [5:0] db9joy1_out,
    output logic [5:0] db9joy2_out,
    output logic       absent,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  phase;
    logic [3:0]  bit_cnt;
    logic [15:0] sr;
    logic        phase_last;

    assign phase_last = (phase == 8'(CLKDIV - 1));
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (enable) state_next = LOAD;
            LOAD:     if (phase_last) state_next = SHIFT_LO;
            SHIFT_LO: if (phase_last) state_next = SHIFT_HI;
            SHIFT_HI: if (phase_last) state_next = (bit_cnt == 4'd15) ? LATCH : SHIFT_LO;
            LATCH:    state_next = enable ? LOAD : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so the pins align with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= 8'd0;
            bit_cnt     <= 4'd0;
            sr          <= 16'h0000;
            joy_load_n  <= 1'b1;
            joy_clk     <= 1'b0;
            db9joy1_out <= 6'h3F;
            db9joy2_out <= 6'h3F;
            absent      <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_next;
            joy_load_n <= (state_next != LOAD);
            joy_clk    <= (state_next == SHIFT_HI);
            frame_done <= (state_next == LATCH);

            if (state_next != state || state == IDLE || state == LATCH) begin
                phase <= 8'd0;
            end else begin
                phase <= phase + 8'd1;
            end

            if (state == LOAD) begin
                bit_cnt <= 4'd0;
            end else if (state == SHIFT_HI && phase_last && bit_cnt != 4'd15) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (state == SHIFT_LO && phase_last) begin
                sr <= {sr[14:0], joy_data};
            end

            // sr is complete once the last SHIFT_HI ends; publish on the way into LATCH.
            if (state_next == LATCH) begin
                if (sr == 16'h0000) begin
                    db9joy1_out <= 6'h3F;
                    db9joy2_out <= 6'h3F;
                    absent      <= 1'b1;
                end else begin
                    db9joy1_out <= sr[15:10];
                    db9joy2_out <= sr[7:2];
                    absent      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench for joy_serial_reader: 74HC165 chain models, a frame scoreboard and
// scenario tasks for CLKDIV=4 and CLKDIV=1 instances.
module tb_joy_serial_reader;

  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, enable1;
  logic        load_n, jclk, jdata, load_n1, jclk1, jdata1;
  logic [5:0]  j1, j2, k1, k2;
  logic        absent, busy, fdone, absent1, busy1, fdone1;
  logic [15:0] chain_word, chain_word1;
  logic [15:0] chain_sr = 16'h0000;
  logic [15:0] chain_sr1 = 16'h0000;
  logic        jclk_d = 1'b0;
  logic        jclk1_d = 1'b0;
  logic        mon_prev1 = 1'b0;

  logic [12:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int viol = 0;
  int rises1 = 0;

  joy_serial_reader #(.CLKDIV(DIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .joy_load_n(load_n), .joy_clk(jclk), .joy_data(jdata),
    .db9joy1_out(j1), .db9joy2_out(j2),
    .absent(absent), .busy(busy), .frame_done(fdone)
  );

  joy_serial_reader #(.CLKDIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable1),
    .joy_load_n(load_n1), .joy_clk(jclk1), .joy_data(jdata1),
    .db9joy1_out(k1), .db9joy2_out(k2),
    .absent(absent1), .busy(busy1), .frame_done(fdone1)
  );

  // 74HC165 chains: parallel load while load is low, shift on each rising shift clock.
  always @(posedge clk) begin
    if (load_n === 1'b0) chain_sr <= chain_word;
    else if (jclk === 1'b1 && jclk_d === 1'b0) chain_sr <= {chain_sr[14:0], 1'b0};
    jclk_d <= jclk;
    if (load_n1 === 1'b0) chain_sr1 <= chain_word1;
    else if (jclk1 === 1'b1 && jclk1_d === 1'b0) chain_sr1 <= {chain_sr1[14:0], 1'b0};
    jclk1_d <= jclk1;
  end
  assign jdata  = chain_sr[15];
  assign jdata1 = chain_sr1[15];

  // Protocol monitor: load and shift clock never active together; count shift clock rises.
  always @(negedge clk) begin
    if (load_n === 1'b0 && jclk === 1'b1) viol++;
    if (load_n1 === 1'b0 && jclk1 === 1'b1) viol++;
    if (jclk1 === 1'b1 && mon_prev1 === 1'b0) rises1++;
    mon_prev1 <= jclk1;
  end

  function automatic logic [12:0] expect_of(input logic [15:0] w);
    if (w == 16'h0000) return {1'b1, 6'h3F, 6'h3F};
    return {1'b0, w[15:10], w[7:2]};
  endfunction

  task automatic wait_fdone(input bit which, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (((which ? fdone1 : fdone) !== 1'b1) && c < 400);
    if ((which ? fdone1 : fdone) !== 1'b1) c = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (load_n !== 1'b1) begin n_err++; $display("FAIL reset_load_n got=%b exp=1", load_n); end
    n_vec++; if (jclk !== 1'b0) begin n_err++; $display("FAIL reset_joy_clk got=%b exp=0", jclk); end
    n_vec++; if ({j1, j2} !== 12'hFFF) begin n_err++; $display("FAIL reset_joy got=%h exp=fff", {j1, j2}); end
    n_vec++; if ({absent, busy, fdone} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {absent, busy, fdone}); end
    n_vec++; if ({load_n1, jclk1, busy1} !== 3'b100) begin n_err++; $display("FAIL reset_div1 got=%b exp=100", {load_n1, jclk1, busy1}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame;
    logic [12:0] exp_v;
    int done_at;
    done_at = -1;
    @(negedge clk);
    chain_word = 16'b101111_00_110101_00;
    exp_q.push_back(expect_of(chain_word));
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 0 || i == DIV - 1) begin
        n_vec++; if (load_n !== 1'b0) begin n_err++; $display("FAIL single_load_low i=%0d got=%b exp=0", i, load_n); end
      end
      if (i == DIV) begin
        n_vec++; if (load_n !== 1'b1) begin n_err++; $display("FAIL single_load_end got=%b exp=1", load_n); end
      end
      if (fdone === 1'b1) begin done_at = i; break; end
      @(negedge clk);
    end
    n_vec++; if (done_at != 33 * DIV) begin n_err++; $display("FAIL single_latency got=%0d exp=%0d", done_at, 33 * DIV); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
    n_vec++; if ({absent, j1, j2} !== exp_v) begin n_err++; $display("FAIL single_frame got=%h exp=%h", {absent, j1, j2}, exp_v); end
    @(negedge clk);
    n_vec++; if ({busy, fdone, load_n} !== 3'b001) begin n_err++; $display("FAIL single_idle got=%b exp=001", {busy, fdone, load_n}); end
  endtask

  task automatic test_back_to_back;
    logic [12:0] exp_v;
    int c;
    @(negedge clk);
    chain_word = 16'hFFFF;
    exp_q.push_back(expect_of(chain_word));
    enable = 1'b1;
    wait_fdone(1'b0, c);
    n_vec++; if (c < 0) begin n_err++; $display("FAIL b2b_timeout1 got=none exp=frame_done"); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
    n_vec++; if ({absent, j1, j2} !== exp_v) begin n_err++; $display("FAIL b2b_frame1 got=%h exp=%h", {absent, j1, j2}, exp_v); end
    chain_word = 16'h0000;
    exp_q.push_back(expect_of(chain_word));
    wait_fdone(1'b0, c);
    enable = 1'b0;
    n_vec++; if (c != 33 * DIV + 1) begin n_err++; $display("FAIL b2b_spacing got=%0d exp=%0d", c, 33 * DIV + 1); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h0000;
    n_vec++; if ({absent, j1, j2} !== exp_v) begin n_err++; $display("FAIL b2b_frame2 got=%h exp=%h", {absent, j1, j2}, exp_v); end
    @(negedge clk);
    n_vec++; if ({busy, fdone} !== 2'b00) begin n_err++; $display("FAIL b2b_idle got=%b exp=00", {busy, fdone}); end
  endtask

  task automatic test_enable_drop;
    logic [12:0] exp_v;
    int c, lows;
    @(negedge clk);
    chain_word = 16'($urandom_range(1, 16'hFFFF));
    exp_q.push_back(expect_of(chain_word));
    enable = 1'b1;
    repeat (20) @(negedge clk);
    enable = 1'b0;
    wait_fdone(1'b0, c);
    n_vec++; if (c != 33 * DIV - 19) begin n_err++; $display("FAIL drop_latency got=%0d exp=%0d", c, 33 * DIV - 19); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
    n_vec++; if ({absent, j1, j2} !== exp_v) begin n_err++; $display("FAIL drop_frame got=%h exp=%h", {absent, j1, j2}, exp_v); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy got=%b exp=0", busy); end
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (load_n !== 1'b1) lows++;
    end
    n_vec++; if (lows != 0) begin n_err++; $display("FAIL drop_load_quiet got=%0d exp=0", lows); end
  endtask

  task automatic test_reset_midframe;
    logic [12:0] exp_v;
    int c, pulses;
    @(negedge clk);
    chain_word = 16'h0303;
    exp_q.push_back(expect_of(chain_word));
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_fdone(1'b0, c);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
    n_vec++; if ({absent, j1, j2} !== exp_v) begin n_err++; $display("FAIL midrst_pre got=%h exp=%h", {absent, j1, j2}, exp_v); end
    repeat (3) @(negedge clk);
    chain_word = 16'($urandom_range(1, 16'hFFFF));
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (65) @(negedge clk);
    n_vec++; if (jclk !== 1'b1) begin n_err++; $display("FAIL midrst_in_hi got=%b exp=1", jclk); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++; if ({j1, j2} !== 12'hFFF) begin n_err++; $display("FAIL midrst_joy got=%h exp=fff", {j1, j2}); end
    n_vec++; if ({jclk, busy, load_n, absent} !== 4'b0010) begin n_err++; $display("FAIL midrst_pins got=%b exp=0010", {jclk, busy, load_n, absent}); end
    pulses = 0;
    repeat (150) begin
      if (fdone === 1'b1) pulses++;
      @(negedge clk);
    end
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL midrst_no_done got=%0d exp=0", pulses); end
  endtask

  task automatic test_clkdiv1;
    logic [12:0] exp_v;
    int c;
    @(negedge clk);
    chain_word1 = 16'($urandom_range(0, 16'hFFFF));
    exp_q.push_back(expect_of(chain_word1));
    enable1 = 1'b1;
    wait_fdone(1'b1, c);
    n_vec++; if (c != 34) begin n_err++; $display("FAIL div1_latency got=%0d exp=34", c); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
    n_vec++; if ({absent1, k1, k2} !== exp_v) begin n_err++; $display("FAIL div1_frame1 got=%h exp=%h", {absent1, k1, k2}, exp_v); end
    chain_word1 = 16'($urandom_range(1, 16'hFFFF));
    exp_q.push_back(expect_of(chain_word1));
    rises1 = 0;
    wait_fdone(1'b1, c);
    enable1 = 1'b0;
    n_vec++; if (c != 34) begin n_err++; $display("FAIL div1_spacing got=%0d exp=34", c); end
    n_vec++; if (rises1 != 16) begin n_err++; $display("FAIL div1_rises got=%0d exp=16", rises1); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
    n_vec++; if ({absent1, k1, k2} !== exp_v) begin n_err++; $display("FAIL div1_frame2 got=%h exp=%h", {absent1, k1, k2}, exp_v); end
    @(negedge clk);
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL div1_idle got=%b exp=0", busy1); end
    n_vec++; if (viol != 0) begin n_err++; $display("FAIL protocol_overlap got=%0d exp=0", viol); end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    enable1 = 1'b0;
    chain_word = 16'h0000;
    chain_word1 = 16'h0000;
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_enable_drop;
    test_reset_midframe;
    test_clkdiv1;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
